// File: rtl/soc_run_ctrl_if.sv
// Board-side signal bundle for the run/halt/step sequencer.
//   btn_n       raw run/halt/reset button, active-low, asynchronous
//   step_n      raw single-step button, active-low, asynchronous
//   cpu_reset   reset to the SoC, active-high
//   cpu_en      clock-enable to the SoC core
//   halted      1 while the core is halted or single-stepping
//   step_count  steps executed since the last power-on reset
// slave: the sequencer side.  master: the board / stimulus side.
interface soc_run_ctrl_if;
  logic        btn_n;
  logic        step_n;
  logic        cpu_reset;
  logic        cpu_en;
  logic        halted;
  logic [15:0] step_count;

  modport slave (
    input  btn_n,
    input  step_n,
    output cpu_reset,
    output cpu_en,
    output halted,
    output step_count
  );

  modport master (
    output btn_n,
    output step_n,
    input  cpu_reset,
    input  cpu_en,
    input  halted,
    input  step_count
  );
endinterface

// File: rtl/soc_run_ctrl.sv
// Run/halt/step/reset sequencer for the RiSC-16 SoC.
// Synchronises and debounces the two board buttons, generates the SoC
// power-on / long-press reset and drives the core clock-enable so the core
// can free-run, halt or single-step.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    soc_run_ctrl_if.slave: btn_n, step_n in; cpu_reset, cpu_en,
//          halted, step_count out
module soc_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int POR_CYCLES      = 32
) (
  input  logic          clk,
  input  logic          reset,
  soc_run_ctrl_if.slave bus
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int POR_W  = $clog2(POR_CYCLES + 1);

  typedef enum logic [1:0] {ST_POR, ST_RUN, ST_HALT, ST_STEP} state_t;

  // Hold counter increments but sticks at LONG_CYCLES, which also marks
  // "long press already reported" for the rest of the press.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    if (v == HOLD_W'(LONG_CYCLES)) return v;
    else                           return v + 1'b1;
  endfunction

  // Bit 0 = btn_n, bit 1 = step_n throughout the input path.
  logic [1:0]      raw;
  logic [1:0]      sync_p0, sync_p1;
  logic [1:0]      stable, stable_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      db_done;

  logic [HOLD_W-1:0] hold_cnt;
  logic              btn_press_acc;
  logic              long_ev, short_ev, step_ev;

  state_t       state, state_nxt;
  logic [POR_W-1:0] por_cnt;
  logic [15:0]  step_cnt;
  logic         cpu_reset_o, cpu_en_o, halted_o;

  assign raw = {bus.step_n, bus.btn_n};

  always_comb begin
    db_done = '0;
    for (int i = 0; i < 2; i++)
      db_done[i] = (sync_p1[i] != stable[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
  end

  // Stage p0/p1: two-flop synchroniser, then debounce into stable level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '1;
      sync_p1  <= '1;
      stable   <= '1;
      stable_d <= '1;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_done[i]) begin
          db_cnt[i] <= '0;
          stable[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage events: edge pulses from the stable levels
  // The hold counter restarts on the very edge the press is accepted, so it
  // reads 0 on the first cycle the stable level is low.
  assign btn_press_acc = db_done[0] && !sync_p1[0];
  assign long_ev  = !stable[0] && (hold_cnt == HOLD_W'(LONG_CYCLES - 1));
  assign short_ev = stable[0] && !stable_d[0] && (hold_cnt != HOLD_W'(LONG_CYCLES));
  assign step_ev  = !stable[1] && stable_d[1];

  always_ff @(posedge clk) begin
    if (reset)              hold_cnt <= '0;
    else if (btn_press_acc) hold_cnt <= '0;
    else if (!stable[0])    hold_cnt <= hold_sat_inc(hold_cnt);
  end

  // Stage FSM: state register, next state, Moore outputs
  always_ff @(posedge clk) begin
    if (reset) state <= ST_POR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (long_ev) begin
      state_nxt = ST_POR;
    end else begin
      case (state)
        ST_POR:  if (por_cnt == POR_W'(POR_CYCLES - 1)) state_nxt = ST_RUN;
        ST_RUN:  if (short_ev) state_nxt = ST_HALT;
        ST_HALT: if (short_ev)     state_nxt = ST_RUN;
                 else if (step_ev) state_nxt = ST_STEP;
        ST_STEP: state_nxt = ST_HALT;
        default: state_nxt = ST_POR;
      endcase
    end
  end

  always_comb begin
    cpu_reset_o = 1'b0;
    cpu_en_o    = 1'b0;
    halted_o    = 1'b0;
    case (state)
      ST_POR:  cpu_reset_o = 1'b1;
      ST_RUN:  cpu_en_o    = 1'b1;
      ST_HALT: halted_o    = 1'b1;
      ST_STEP: begin
        cpu_en_o = 1'b1;
        halted_o = 1'b1;
      end
      default: cpu_reset_o = 1'b1;
    endcase
  end

  // A long press restarts the POR count even when already in POR.
  always_ff @(posedge clk) begin
    if (reset)                        por_cnt <= '0;
    else if (long_ev || state != ST_POR) por_cnt <= '0;
    else                              por_cnt <= por_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                                         step_cnt <= '0;
    else if (long_ev)                                  step_cnt <= '0;
    else if (state == ST_HALT && state_nxt == ST_STEP) step_cnt <= step_cnt + 16'd1;
  end

  assign bus.cpu_reset  = cpu_reset_o;
  assign bus.cpu_en     = cpu_en_o;
  assign bus.halted     = halted_o;
  assign bus.step_count = step_cnt;
endmodule

// File: tb/tb_soc_run_ctrl.sv
// Directed bench for soc_run_ctrl with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// POR_CYCLES=8. Inputs change and outputs are sampled 1 ns after posedge.
module tb_soc_run_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  soc_run_ctrl_if bus_if ();

  soc_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .POR_CYCLES     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic e, input logic h);
    chk({tag, ".cpu_reset"}, 16'(bus_if.cpu_reset), 16'(r));
    chk({tag, ".cpu_en"},    16'(bus_if.cpu_en),    16'(e));
    chk({tag, ".halted"},    16'(bus_if.halted),    16'(h));
  endtask

  // Short btn_n press of 10 cycles; the release is accepted 6 cycles later
  // and the state changes on the 7th edge after the release.
  task automatic short_press(input string tag, input logic halted_after);
    bus_if.btn_n = 1'b0;
    tick(10);
    bus_if.btn_n = 1'b1;
    tick(6);
    chk({tag, ".pre"}, 16'(bus_if.halted), 16'(!halted_after));
    tick(1);
    chk_out(tag, 1'b0, !halted_after, halted_after);
    tick(3);
  endtask

  // One step_n press in HALT: single cpu_en pulse 7 edges after the press.
  task automatic step_pulse(input string tag, input logic [15:0] count_after);
    bus_if.step_n = 1'b0;
    tick(6);
    chk_out({tag, ".pre"}, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out({tag, ".step"}, 1'b0, 1'b1, 1'b1);
    chk({tag, ".count"}, bus_if.step_count, count_after);
    tick(1);
    chk_out({tag, ".back"}, 1'b0, 1'b0, 1'b1);
    bus_if.step_n = 1'b1;
    tick(8);
    chk_out({tag, ".rel"}, 1'b0, 1'b0, 1'b1);
    chk({tag, ".count_rel"}, bus_if.step_count, count_after);
  endtask

  initial begin
    reset         = 1'b1;
    bus_if.btn_n  = 1'b1;
    bus_if.step_n = 1'b1;
    tick(3);
    chk_out("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.count", bus_if.step_count, 16'd0);

    // Power-on reset: 8 cycles of cpu_reset after reset drops.
    reset = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk_out("por", 1'b1, 1'b0, 1'b0);
    end
    tick(1);
    chk_out("por.run", 1'b0, 1'b1, 1'b0);

    // Short presses toggle RUN -> HALT -> RUN.
    short_press("halt1", 1'b1);
    short_press("run1", 1'b0);

    // Three single steps from HALT.
    short_press("halt2", 1'b1);
    step_pulse("step1", 16'd1);
    step_pulse("step2", 16'd2);
    step_pulse("step3", 16'd3);

    // Long press from RUN: stable at edge 6, POR at edge 26, RUN at edge 34.
    short_press("run2", 1'b0);
    bus_if.btn_n = 1'b0;
    tick(25);
    chk_out("long.pre", 1'b0, 1'b1, 1'b0);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      chk_out("long.por", 1'b1, 1'b0, 1'b0);
      if (i == 0) chk("long.count", bus_if.step_count, 16'd0);
      if (i == 4) bus_if.btn_n = 1'b1;
      tick(1);
    end
    chk_out("long.run", 1'b0, 1'b1, 1'b0);
    tick(15);
    chk_out("long.norel", 1'b0, 1'b1, 1'b0);

    // btn_n glitches in RUN never get accepted.
    repeat (6) begin
      bus_if.btn_n = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        chk_out("glitch.btn", 1'b0, 1'b1, 1'b0);
      end
      bus_if.btn_n = 1'b1;
      tick(1);
      chk_out("glitch.btn", 1'b0, 1'b1, 1'b0);
    end
    tick(8);
    chk_out("glitch.btn.end", 1'b0, 1'b1, 1'b0);

    // step_n glitches in HALT never produce a step.
    short_press("halt3", 1'b1);
    repeat (6) begin
      bus_if.step_n = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        chk_out("glitch.step", 1'b0, 1'b0, 1'b1);
      end
      bus_if.step_n = 1'b1;
      tick(1);
      chk_out("glitch.step", 1'b0, 1'b0, 1'b1);
    end
    tick(8);
    chk("glitch.step.count", bus_if.step_count, 16'd0);

    // Simultaneous short_ev and step_ev in HALT: RUN wins, no step.
    bus_if.btn_n = 1'b0;
    tick(10);
    bus_if.btn_n  = 1'b1;
    bus_if.step_n = 1'b0;
    tick(6);
    chk_out("both.pre", 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_out("both.run", 1'b0, 1'b1, 1'b0);
    chk("both.count", bus_if.step_count, 16'd0);
    tick(1);
    chk_out("both.run2", 1'b0, 1'b1, 1'b0);
    bus_if.step_n = 1'b1;
    tick(10);

    // Reset asserted while in STEP.
    short_press("halt4", 1'b1);
    bus_if.step_n = 1'b0;
    tick(7);
    chk_out("midstep.step", 1'b0, 1'b1, 1'b1);
    chk("midstep.count", bus_if.step_count, 16'd1);
    reset         = 1'b1;
    bus_if.step_n = 1'b1;
    tick(1);
    chk_out("midstep.reset", 1'b1, 1'b0, 1'b0);
    chk("midstep.reset.count", bus_if.step_count, 16'd0);
    reset = 1'b0;
    tick(7);
    chk_out("midstep.por", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("midstep.run", 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
